// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM. It steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB/MDU and drives the datapath strobes from the
// current state, the instruction and the comparator flags.
//
// state  | meaning
// FETCH  | instruction fetch, wait for mem_rdy, then latch IR and PC+4
// DECODE | IR stable, no strobes
// EXEC   | branch/jump resolution, MDU start, class dispatch
// MEM    | data read or write, wait for mem_rdy
// WB     | single register-file write
// MDU    | fixed-latency multiply/divide stall
module mc_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int HAS_MDU = 1,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Breq,
  input  logic        Brlt,
  input  logic        Breqz,
  input  logic        Brltz,
  input  logic        mem_rdy,
  output logic        IMRd,
  output logic        IRWr,
  output logic        PCWr,
  output logic [1:0]  PCSel,
  output logic        DMRd,
  output logic        DMWr,
  output logic        RegWr,
  output logic [1:0]  WDSel,
  output logic [1:0]  RDSel,
  output logic        Br,
  output logic        J,
  output logic        mdu_start,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [1:0] WD_fromALU = 2'd0;
  localparam logic [1:0] WD_fromMEM = 2'd1;
  localparam logic [1:0] WD_fromPC  = 2'd2;
  localparam logic [1:0] RD_fromRT  = 2'd0;
  localparam logic [1:0] RD_fromRD  = 2'd1;
  localparam logic [1:0] RD_RA      = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDU    = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic [5:0] op, funct;
  logic [4:0] rt;
  logic is_r, is_i, is_b, is_l, is_s, is_j, is_jal, is_jr, is_jalr, is_mdu;
  logic br_cond, is_jump, mdu_ok;

  // Brlt and the unused instruction fields are not needed by this decoder.
  logic unused_bits;
  assign unused_bits = &{1'b0, Brlt, instr[25:21], instr[15:6]};

  assign op     = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign state  = state_q;
  assign mdu_ok = (HAS_MDU != 0);

  // Instruction class decode and branch condition.
  always_comb begin
    is_r    = 1'b0;
    is_jr   = 1'b0;
    is_jalr = 1'b0;
    is_mdu  = 1'b0;
    if (op == 6'h00) begin
      case (funct)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h10, 6'h12,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
        6'h26, 6'h27, 6'h2a, 6'h2b:             is_r    = 1'b1;
        6'h08:                                  is_jr   = 1'b1;
        6'h09:                                  is_jalr = 1'b1;
        6'h18, 6'h19, 6'h1a, 6'h1b:             is_mdu  = 1'b1;
        default: ;
      endcase
    end
    is_i   = (op >= 6'h08) && (op <= 6'h0f);
    is_b   = (op == 6'h01) || ((op >= 6'h04) && (op <= 6'h07));
    is_l   = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
             (op == 6'h24) || (op == 6'h25);
    is_s   = (op == 6'h28) || (op == 6'h29) || (op == 6'h2b);
    is_j   = (op == 6'h02);
    is_jal = (op == 6'h03);
    is_jump = is_j | is_jal | is_jr | is_jalr;
    case (op)
      6'h04:   br_cond = Breq;
      6'h05:   br_cond = ~Breq;
      6'h06:   br_cond = Brltz | Breqz;
      6'h07:   br_cond = ~(Brltz | Breqz);
      6'h01:   br_cond = (rt == 5'd0) ? Brltz :
                         (rt == 5'd1) ? ~Brltz : 1'b0;
      default: br_cond = 1'b0;
    endcase
  end

  // State register and MDU down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_rdy) state_q <= S_DECODE;
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (is_b)                   state_q <= S_FETCH;
          else if (is_jal | is_jalr)  state_q <= S_WB;
          else if (is_j | is_jr)      state_q <= S_FETCH;
          else if (is_l | is_s)       state_q <= S_MEM;
          else if (is_mdu && mdu_ok) begin
            state_q <= S_MDU;
            cnt_q   <= CNT_W'(MDU_LAT - 1);
          end
          else if (is_r | is_i)       state_q <= S_WB;
          else                        state_q <= S_FETCH;
        end
        S_MEM: if (mem_rdy) state_q <= is_l ? S_WB : S_FETCH;
        S_WB:  state_q <= S_FETCH;
        S_MDU: begin
          if (cnt_q == '0) state_q <= S_FETCH;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Combinational strobes; reset forces everything low.
  always_comb begin
    IMRd = 1'b0; IRWr = 1'b0; PCWr = 1'b0; PCSel = 2'd0;
    DMRd = 1'b0; DMWr = 1'b0; RegWr = 1'b0;
    WDSel = WD_fromALU; RDSel = RD_fromRT;
    Br = 1'b0; J = 1'b0; mdu_start = 1'b0; illegal = 1'b0;
    if (!rst) begin
      Br = is_b & br_cond;
      if (is_l)                 WDSel = WD_fromMEM;
      else if (is_jal | is_jalr) WDSel = WD_fromPC;
      if (is_jal)               RDSel = RD_RA;
      else if (is_r | is_jalr)  RDSel = RD_fromRD;
      case (state_q)
        S_FETCH: begin
          IMRd = 1'b1;
          if (mem_rdy) begin
            IRWr = 1'b1;
            PCWr = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_b) begin
            PCWr  = br_cond;
            PCSel = 2'd1;
          end else if (is_jump) begin
            J     = 1'b1;
            PCWr  = 1'b1;
            PCSel = 2'd2;
          end else if (is_l | is_s) begin
          end else if (is_mdu && mdu_ok) begin
            mdu_start = 1'b1;
          end else if (!(is_r | is_i)) begin
            illegal = 1'b1;
          end
        end
        S_MEM: begin
          DMRd = is_l;
          DMWr = is_s;
        end
        S_WB: RegWr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed cycle-by-cycle checks of the mc_ctrl sequencer.
// Two instances share all inputs: one with a 4-cycle MDU, one without MDU.
module tb_mc_ctrl;

  localparam logic [31:0] ADDU = 32'h0022_1821;
  localparam logic [31:0] LW   = 32'h8C22_0000;
  localparam logic [31:0] SW   = 32'hAC22_0000;
  localparam logic [31:0] BEQ  = 32'h1022_0004;
  localparam logic [31:0] BGEZ5 = 32'h0425_0004;
  localparam logic [31:0] JAL  = 32'h0C00_0010;
  localparam logic [31:0] JR   = 32'h03E0_0008;
  localparam logic [31:0] MULT = 32'h0022_0018;
  localparam logic [31:0] BAD  = 32'hFC00_0000;

  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC = 2'd2;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic Breq = 0, Brlt = 0, Breqz = 0, Brltz = 0, mem_rdy = 0;

  logic IMRd, IRWr, PCWr, DMRd, DMWr, RegWr, Br, J, mdu_start, illegal;
  logic [1:0] PCSel, WDSel, RDSel;
  logic [2:0] state;
  logic n_IMRd, n_IRWr, n_PCWr, n_DMRd, n_DMWr, n_RegWr, n_Br, n_J, n_mdu_start, n_illegal;
  logic [1:0] n_PCSel, n_WDSel, n_RDSel;
  logic [2:0] n_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.MDU_LAT(4), .HAS_MDU(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .Breq(Breq), .Brlt(Brlt),
    .Breqz(Breqz), .Brltz(Brltz), .mem_rdy(mem_rdy),
    .IMRd(IMRd), .IRWr(IRWr), .PCWr(PCWr), .PCSel(PCSel), .DMRd(DMRd),
    .DMWr(DMWr), .RegWr(RegWr), .WDSel(WDSel), .RDSel(RDSel), .Br(Br),
    .J(J), .mdu_start(mdu_start), .illegal(illegal), .state(state));

  mc_ctrl #(.MDU_LAT(4), .HAS_MDU(0), .CNT_W(8)) dut_nomdu (
    .clk(clk), .rst(rst), .instr(instr), .Breq(Breq), .Brlt(Brlt),
    .Breqz(Breqz), .Brltz(Brltz), .mem_rdy(mem_rdy),
    .IMRd(n_IMRd), .IRWr(n_IRWr), .PCWr(n_PCWr), .PCSel(n_PCSel), .DMRd(n_DMRd),
    .DMWr(n_DMWr), .RegWr(n_RegWr), .WDSel(n_WDSel), .RDSel(n_RDSel), .Br(n_Br),
    .J(n_J), .mdu_start(n_mdu_start), .illegal(n_illegal), .state(n_state));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rdy = 1'b1; instr = ADDU;
    tick(); tick();
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if ({IMRd, IRWr, PCWr, DMRd, DMWr, RegWr, mdu_start, illegal} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes got %b want 00000000",
               {IMRd, IRWr, PCWr, DMRd, DMWr, RegWr, mdu_start, illegal});
    end
    checks++;
    if ({PCSel, WDSel, RDSel, Br, J} !== 8'h00) begin
      errors++; $display("FAIL reset_selects got %b want 00000000", {PCSel, WDSel, RDSel, Br, J});
    end
    rst = 1'b0;
  endtask

  task automatic test_addu();
    logic [2:0] es [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic       ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       ei [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    instr = ADDU; mem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== es[i]) begin errors++; $display("FAIL addu_state c%0d got %0d want %0d", i, state, es[i]); end
      checks++;
      if (RegWr !== ew[i]) begin errors++; $display("FAIL addu_regwr c%0d got %b want %b", i, RegWr, ew[i]); end
      checks++;
      if ({IRWr, PCWr} !== {ei[i], ei[i]}) begin
        errors++; $display("FAIL addu_irwr_pcwr c%0d got %b want %b", i, {IRWr, PCWr}, {ei[i], ei[i]});
      end
      if (i == 3) begin
        checks++;
        if ({WDSel, RDSel} !== {WD_ALU, RD_RD}) begin
          errors++; $display("FAIL addu_sel got %b want %b", {WDSel, RDSel}, {WD_ALU, RD_RD});
        end
      end
      tick();
    end
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL addu_end got %0d want 0", state); end
  endtask

  task automatic test_load();
    logic       rdy [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    logic [2:0] es  [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    logic       eim [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic       edr [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    instr = LW;
    for (int i = 0; i < 10; i++) begin
      mem_rdy = rdy[i];
      #1;
      checks++;
      if (state !== es[i]) begin errors++; $display("FAIL lw_state c%0d got %0d want %0d", i, state, es[i]); end
      checks++;
      if ({IMRd, DMRd, DMWr} !== {eim[i], edr[i], 1'b0}) begin
        errors++; $display("FAIL lw_mem c%0d got %b want %b", i, {IMRd, DMRd, DMWr}, {eim[i], edr[i], 1'b0});
      end
      checks++;
      if ({RegWr, IRWr} !== {(i == 9), (i == 3)}) begin
        errors++; $display("FAIL lw_wr c%0d got %b want %b", i, {RegWr, IRWr}, {(i == 9), (i == 3)});
      end
      if (i == 9) begin
        checks++;
        if ({WDSel, RDSel} !== {WD_MEM, RD_RT}) begin
          errors++; $display("FAIL lw_sel got %b want %b", {WDSel, RDSel}, {WD_MEM, RD_RT});
        end
      end
      tick();
    end
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL lw_end got %0d want 0", state); end
  endtask

  task automatic test_branch();
    logic [31:0] ins [3] = '{BEQ, BEQ, BGEZ5};
    logic        eq  [3] = '{1'b1, 1'b0, 1'b0};
    logic        tk  [3] = '{1'b1, 1'b0, 1'b0};
    mem_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = ins[k]; Breq = eq[k]; Brltz = 1'b0; Breqz = 1'b0;
      #1; tick();
      #1; tick();
      #1;
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL br%0d_state got %0d want 2", k, state); end
      checks++;
      if ({PCWr, PCSel, Br, RegWr} !== {tk[k], 2'd1, tk[k], 1'b0}) begin
        errors++; $display("FAIL br%0d_exec got %b want %b", k, {PCWr, PCSel, Br, RegWr}, {tk[k], 2'd1, tk[k], 1'b0});
      end
      tick();
      #1;
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL br%0d_end got %0d want 0", k, state); end
    end
    Breq = 1'b0;
  endtask

  task automatic test_jal_jr();
    logic [31:0] ins [2] = '{JAL, JR};
    logic [2:0]  nx  [2] = '{3'd4, 3'd0};
    mem_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      instr = ins[k];
      #1; tick();
      #1; tick();
      #1;
      checks++;
      if ({state, J, PCWr, PCSel, RegWr} !== {3'd2, 1'b1, 1'b1, 2'd2, 1'b0}) begin
        errors++; $display("FAIL jmp%0d_exec got %b want %b", k, {state, J, PCWr, PCSel, RegWr}, {3'd2, 1'b1, 1'b1, 2'd2, 1'b0});
      end
      tick();
      #1;
      checks++;
      if (state !== nx[k]) begin errors++; $display("FAIL jmp%0d_next got %0d want %0d", k, state, nx[k]); end
      if (k == 0) begin
        checks++;
        if ({RegWr, WDSel, RDSel} !== {1'b1, WD_PC, RD_RA}) begin
          errors++; $display("FAIL jal_wb got %b want %b", {RegWr, WDSel, RDSel}, {1'b1, WD_PC, RD_RA});
        end
        tick();
        #1;
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL jal_end got %0d want 0", state); end
      end
    end
  endtask

  task automatic test_mdu();
    instr = MULT; mem_rdy = 1'b1;
    #1; tick();
    #1; tick();
    #1;
    checks++;
    if ({mdu_start, illegal, RegWr} !== 3'b100) begin
      errors++; $display("FAIL mdu_exec got %b want 100", {mdu_start, illegal, RegWr});
    end
    checks++;
    if ({n_mdu_start, n_illegal, n_RegWr, n_PCWr} !== 4'b0100) begin
      errors++; $display("FAIL nomdu_exec got %b want 0100", {n_mdu_start, n_illegal, n_RegWr, n_PCWr});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({state, mdu_start, RegWr} !== {3'd5, 2'b00}) begin
        errors++; $display("FAIL mdu_busy c%0d got %b want %b", i, {state, mdu_start, RegWr}, {3'd5, 2'b00});
      end
      if (i == 0) begin
        checks++;
        if (n_state !== 3'd0) begin errors++; $display("FAIL nomdu_next got %0d want 0", n_state); end
      end
      tick();
    end
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL mdu_end got %0d want 0", state); end
  endtask

  task automatic test_illegal();
    instr = BAD; mem_rdy = 1'b1;
    #1; tick();
    #1; tick();
    #1;
    checks++;
    if ({illegal, PCWr, RegWr, mdu_start, J} !== 5'b10000) begin
      errors++; $display("FAIL illegal_exec got %b want 10000", {illegal, PCWr, RegWr, mdu_start, J});
    end
    tick();
    #1;
    checks++;
    if ({state, illegal} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL illegal_next got %b want 0000", {state, illegal});
    end
  endtask

  task automatic test_store_reset();
    instr = SW; mem_rdy = 1'b1;
    #1; tick();
    #1; tick();
    #1; tick();
    mem_rdy = 1'b0;
    #1;
    checks++;
    if ({state, DMWr, DMRd} !== {3'd3, 2'b10}) begin
      errors++; $display("FAIL sw_mem1 got %b want %b", {state, DMWr, DMRd}, {3'd3, 2'b10});
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({DMWr, DMRd, IMRd, RegWr} !== 4'b0000) begin
      errors++; $display("FAIL sw_rst_strobes got %b want 0000", {DMWr, DMRd, IMRd, RegWr});
    end
    tick();
    #1;
    checks++;
    if ({state, DMWr} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL sw_rst_state got %b want 0000", {state, DMWr});
    end
    rst = 1'b0; mem_rdy = 1'b1; instr = ADDU;
    #1;
    checks++;
    if ({IMRd, IRWr, PCWr, PCSel} !== 5'b11100) begin
      errors++; $display("FAIL refetch got %b want 11100", {IMRd, IRWr, PCWr, PCSel});
    end
    tick();
    #1;
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL refetch_next got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_load();
    test_branch();
    test_jal_jr();
    test_mdu();
    test_illegal();
    test_store_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
